// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer and the phase blocks it drives.
package phase_sequencer_pkg;

  // Width of a phase index; fixes the 16-phase ceiling.
  localparam int PH_IDX_W = 4;

  // Phase index constants of the reaction-timer game.
  localparam logic [PH_IDX_W-1:0] PH_IDLE   = 4'd0;
  localparam logic [PH_IDX_W-1:0] PH_WAIT   = 4'd1;
  localparam logic [PH_IDX_W-1:0] PH_TIMING = 4'd2;
  localparam logic [PH_IDX_W-1:0] PH_SCORE  = 4'd3;
  localparam logic [PH_IDX_W-1:0] PH_HIGH   = 4'd4;

  // Active-low seven-segment pattern with every segment off.
  localparam logic [7:0] BLANK_HEX = 8'hff;

  // Why the sequencer moves (or does not move) on a given clock.
  typedef enum logic [2:0] {
    EV_HOLD,
    EV_ABORT,
    EV_TIMEOUT,
    EV_DONE,
    EV_ILLEGAL
  } ph_event_e;

endpackage

// File: rtl/phase_timeout_ctr.sv
// Saturating cycle counter that flags when a phase has been active for
// `limit_i` cycles. A limit of zero disables expiry.
module phase_timeout_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise count up while enabled and stop at the limit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != limit_i)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is reported during the last permitted active cycle.
  assign expired_o = enable_i && (limit_i != '0) && (count_q == limit_i - W'(1));

endmodule

// File: rtl/phase_sequencer.sv
// Top-level game-phase sequencer: owns the current phase, drives one-hot
// enables and entry pulses, enforces a per-phase timeout and muxes the
// active phase's LED/HEX buses to the board.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int                       NUM_PHASES     = 5,
  parameter int                       LED_W          = 10,
  parameter int                       HEX_DIGITS     = 4,
  parameter int unsigned              TIMEOUT_CYCLES = 500000000,
  parameter logic [NUM_PHASES-1:0]    HEX_MASK       = 5'b11100
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             abort,
  input  logic [NUM_PHASES-1:0]            ph_done,
  input  logic [NUM_PHASES*PH_IDX_W-1:0]   ph_next,
  input  logic [NUM_PHASES*LED_W-1:0]      ph_ledr,
  input  logic [NUM_PHASES*HEX_DIGITS*8-1:0] ph_hex,
  output logic [NUM_PHASES-1:0]            ph_en,
  output logic [NUM_PHASES-1:0]            ph_entry,
  output logic [PH_IDX_W-1:0]              cur_phase,
  output logic [LED_W-1:0]                 LEDR,
  output logic [HEX_DIGITS*8-1:0]          hex_out,
  output logic                             timeout_flag,
  output logic                             err_flag
);

  // A zero timeout still needs a one-bit counter to keep the netlist legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [PH_IDX_W:0] NUM_PHASES_L = (PH_IDX_W + 1)'(NUM_PHASES);

  logic [PH_IDX_W-1:0]   cur_phase_q;
  logic [PH_IDX_W-1:0]   next_phase_d;
  logic [NUM_PHASES-1:0] ph_en_q;
  logic [NUM_PHASES-1:0] ph_en_d;
  logic [NUM_PHASES-1:0] ph_entry_q;
  logic                  timeout_flag_q;
  logic                  err_flag_q;
  logic                  act_done;
  logic [PH_IDX_W-1:0]   act_next;
  logic                  expired;
  logic                  take;
  ph_event_e             event_d;

  // Timeout counter; phase 0 is the resting phase and never times out.
  phase_timeout_ctr #(
    .W (CNT_W)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (take),
    .enable_i  (cur_phase_q != PH_IDLE),
    .limit_i   (TO_LIMIT),
    .expired_o (expired)
  );

  // Pick out the active phase's done strobe and requested next index.
  always_comb begin
    act_done = 1'b0;
    act_next = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (cur_phase_q == PH_IDX_W'(p)) begin
        act_done = ph_done[p];
        act_next = ph_next[p*PH_IDX_W +: PH_IDX_W];
      end
    end
  end

  // Transition priority: abort, then timeout, then done; otherwise hold.
  always_comb begin
    event_d      = EV_HOLD;
    next_phase_d = cur_phase_q;
    if (abort) begin
      // Abort while already idle is a no-op, so it produces no entry pulse.
      if (cur_phase_q != PH_IDLE) begin
        event_d      = EV_ABORT;
        next_phase_d = PH_IDLE;
      end
    end else if (expired) begin
      event_d      = EV_TIMEOUT;
      next_phase_d = PH_IDLE;
    end else if (act_done) begin
      if ({1'b0, act_next} >= NUM_PHASES_L) begin
        event_d      = EV_ILLEGAL;
        next_phase_d = PH_IDLE;
      end else begin
        // next == current is a deliberate re-entry and still counts as a move.
        event_d      = EV_DONE;
        next_phase_d = act_next;
      end
    end
  end

  assign take = (event_d != EV_HOLD);

  // One-hot decode of the phase being moved into.
  always_comb begin
    ph_en_d = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      ph_en_d[p] = (next_phase_d == PH_IDX_W'(p));
    end
  end

  // Phase register, enables, entry pulse and the two sticky flags.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it is only tested inside the clocked branch.
    if (reset) begin
      cur_phase_q    <= PH_IDLE;
      ph_en_q        <= NUM_PHASES'(1);
      ph_entry_q     <= NUM_PHASES'(1);
      timeout_flag_q <= 1'b0;
      err_flag_q     <= 1'b0;
    end else begin
      cur_phase_q <= next_phase_d;
      ph_en_q     <= ph_en_d;
      ph_entry_q  <= take ? ph_en_d : '0;
      if (event_d == EV_TIMEOUT) begin
        timeout_flag_q <= 1'b1;
      end else if (take && (next_phase_d == PH_WAIT)) begin
        timeout_flag_q <= 1'b0;
      end
      if (event_d == EV_ILLEGAL) begin
        err_flag_q <= 1'b1;
      end
    end
  end

  // Board outputs follow the current phase; masked-off phases show blank digits.
  always_comb begin
    LEDR    = '0;
    hex_out = {HEX_DIGITS{BLANK_HEX}};
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (cur_phase_q == PH_IDX_W'(p)) begin
        LEDR = ph_ledr[p*LED_W +: LED_W];
        if (HEX_MASK[p]) begin
          hex_out = ph_hex[p*HEX_DIGITS*8 +: HEX_DIGITS*8];
        end
      end
    end
  end

  assign cur_phase    = cur_phase_q;
  assign ph_en        = ph_en_q;
  assign ph_entry     = ph_entry_q;
  assign timeout_flag = timeout_flag_q;
  assign err_flag     = err_flag_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: a behavioural model predicts each
// cycle's outputs, pushes them to a queue, and they are popped and compared
// after the clock edge. Directed constant checks cover the key scenarios.
module tb_phase_sequencer;

  localparam int NP  = 5;
  localparam int LW  = 10;
  localparam int HD  = 4;
  localparam int TO  = 8;
  localparam logic [NP-1:0] MASK = 5'b11100;

  logic            clk = 1'b0;
  logic            reset;
  logic            abort;
  logic [NP-1:0]   ph_done;
  logic [NP*4-1:0] ph_next;
  logic [NP*LW-1:0] ph_ledr;
  logic [NP*HD*8-1:0] ph_hex;
  logic [NP-1:0]   ph_en;
  logic [NP-1:0]   ph_entry;
  logic [3:0]      cur_phase;
  logic [LW-1:0]   LEDR;
  logic [HD*8-1:0] hex_out;
  logic            timeout_flag;
  logic            err_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]    ph;
    logic [NP-1:0] en;
    logic [NP-1:0] entry;
    logic          tf;
    logic          ef;
    logic [LW-1:0] led;
    logic [31:0]   hex;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  int            m_phase;
  int            m_cnt;
  logic          m_tf;
  logic          m_ef;
  logic [NP-1:0] m_entry;

  phase_sequencer #(
    .NUM_PHASES     (NP),
    .LED_W          (LW),
    .HEX_DIGITS     (HD),
    .TIMEOUT_CYCLES (TO),
    .HEX_MASK       (MASK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .abort        (abort),
    .ph_done      (ph_done),
    .ph_next      (ph_next),
    .ph_ledr      (ph_ledr),
    .ph_hex       (ph_hex),
    .ph_en        (ph_en),
    .ph_entry     (ph_entry),
    .cur_phase    (cur_phase),
    .LEDR         (LEDR),
    .hex_out      (hex_out),
    .timeout_flag (timeout_flag),
    .err_flag     (err_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit   take;
    int   nxt;
    int   idx;
    exp_t e;
    if (reset) begin
      m_phase = 0; m_cnt = 0; m_tf = 1'b0; m_ef = 1'b0; m_entry = NP'(1);
    end else begin
      take = 0;
      nxt  = m_phase;
      if (abort) begin
        if (m_phase != 0) begin take = 1; nxt = 0; end
      end else if (m_phase != 0 && m_cnt == TO - 1) begin
        take = 1; nxt = 0; m_tf = 1'b1;
      end else if (ph_done[m_phase]) begin
        take = 1;
        idx  = int'(ph_next[m_phase*4 +: 4]);
        if (idx >= NP) begin nxt = 0; m_ef = 1'b1; end
        else nxt = idx;
      end
      if (take && nxt == 1) m_tf = 1'b0;
      if (take) m_cnt = 0;
      else if (m_phase != 0 && m_cnt < TO) m_cnt++;
      m_entry = take ? NP'(1 << nxt) : '0;
      m_phase = nxt;
    end
    e.ph    = 4'(m_phase);
    e.en    = NP'(1 << m_phase);
    e.entry = m_entry;
    e.tf    = m_tf;
    e.ef    = m_ef;
    e.led   = ph_ledr[m_phase*LW +: LW];
    e.hex   = MASK[m_phase] ? ph_hex[m_phase*32 +: 32] : 32'hffffffff;
    sb.push_back(e);
  endtask

  // One clock: predict, clock, then compare away from the edge.
  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      e = sb.pop_front();
      check("cur_phase", 64'(cur_phase), 64'(e.ph));
      check("ph_en", 64'(ph_en), 64'(e.en));
      check("ph_entry", 64'(ph_entry), 64'(e.entry));
      check("timeout_flag", 64'(timeout_flag), 64'(e.tf));
      check("err_flag", 64'(err_flag), 64'(e.ef));
      check("LEDR", 64'(LEDR), 64'(e.led));
      check("hex_out", 64'(hex_out), 64'(e.hex));
    end
  endtask

  task automatic pulse_done(input int p, input logic [3:0] nxt);
    ph_done = '0;
    ph_next = '0;
    ph_done[p] = 1'b1;
    ph_next[p*4 +: 4] = nxt;
    cycle();
    ph_done = '0;
    ph_next = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset   = 1'b1;
    abort   = 1'b0;
    ph_done = '0;
    ph_next = '0;
    for (int p = 0; p < NP; p++) ph_ledr[p*LW +: LW] = LW'(p * 97 + 3);
    ph_hex[0*32 +: 32] = 32'h11111111;
    ph_hex[1*32 +: 32] = 32'h22222222;
    ph_hex[2*32 +: 32] = 32'hC0F9A4B0;
    ph_hex[3*32 +: 32] = 32'h12345678;
    ph_hex[4*32 +: 32] = 32'h9ABCDEF0;
    m_phase = 0; m_cnt = 0; m_tf = 1'b0; m_ef = 1'b0; m_entry = '0;

    // Reset and release: phase 0, entry pulse for exactly one cycle.
    @(negedge clk);
    idle(2);
    reset = 1'b0;
    check("rst_entry_hi", 64'(ph_entry), 64'(5'b00001));
    check("rst_hex_blank", 64'(hex_out), 64'h0000_0000_ffff_ffff);
    idle(1);
    check("rst_en", 64'(ph_en), 64'(5'b00001));
    check("rst_entry_lo", 64'(ph_entry), 64'(0));
    idle(10);
    check("idle_no_timeout", 64'(cur_phase), 64'(0));

    // 0 -> 1 -> 2 on successive done strobes.
    pulse_done(0, 4'd1);
    check("to_ph1", 64'(cur_phase), 64'(1));
    idle(2);
    pulse_done(1, 4'd2);
    check("to_ph2", 64'(cur_phase), 64'(2));
    check("ph2_entry", 64'(ph_entry), 64'(5'b00100));
    check("ph2_hex", 64'(hex_out), 64'(32'hC0F9A4B0));
    idle(1);
    check("ph2_entry_once", 64'(ph_entry), 64'(0));

    // Done from an inactive phase is ignored.
    pulse_done(4, 4'd0);
    check("inactive_done", 64'(cur_phase), 64'(2));

    // Re-entry of the same phase pulses entry and restarts the timeout.
    pulse_done(2, 4'd2);
    check("reentry_entry", 64'(ph_entry), 64'(5'b00100));
    idle(6);
    check("reentry_no_to", 64'(cur_phase), 64'(2));
    pulse_done(2, 4'd0);
    check("back_to_0", 64'(cur_phase), 64'(0));

    // Timeout in phase 1 on the 8th active cycle.
    pulse_done(0, 4'd1);
    idle(TO - 1);
    check("pre_timeout", 64'(cur_phase), 64'(1));
    idle(1);
    check("timeout_phase", 64'(cur_phase), 64'(0));
    check("timeout_flag_set", 64'(timeout_flag), 64'(1));
    idle(3);
    pulse_done(0, 4'd1);
    check("timeout_flag_clr", 64'(timeout_flag), 64'(0));

    // Illegal next index from phase 3.
    pulse_done(1, 4'd3);
    check("to_ph3", 64'(cur_phase), 64'(3));
    pulse_done(3, 4'd9);
    check("illegal_phase", 64'(cur_phase), 64'(0));
    check("err_set", 64'(err_flag), 64'(1));

    // Abort beats a simultaneous done; holding abort in phase 0 is quiet.
    pulse_done(0, 4'd2);
    abort = 1'b1;
    pulse_done(2, 4'd3);
    check("abort_wins", 64'(cur_phase), 64'(0));
    check("abort_entry", 64'(ph_entry), 64'(5'b00001));
    idle(3);
    check("abort_hold_quiet", 64'(ph_entry), 64'(0));
    check("err_persist", 64'(err_flag), 64'(1));
    abort = 1'b0;

    // Reset mid-phase returns to idle and clears the error flag.
    pulse_done(0, 4'd4);
    check("to_ph4", 64'(cur_phase), 64'(4));
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("reset_mid_phase", 64'(cur_phase), 64'(0));
    check("err_cleared", 64'(err_flag), 64'(0));
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
